// File: rtl/imem_responder.sv
// Instruction memory responder: four per-thread banks answering one fetch per cycle,
// with a program-load port that borrows a bank only when the fetch is not using it.
module imem_responder #(
    parameter int          XLEN       = 32,
    parameter int          ADDR_LEN   = 15,
    parameter int          BANK_WORDS = 256,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_valid,
    input  logic [ADDR_LEN-1:0] fetch_addr,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_data,
    output logic [1:0]          rsp_tid,
    output logic                rsp_fault,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [1:0]          ld_tid,
    input  logic [ADDR_LEN-3:0] ld_idx,
    input  logic [XLEN-1:0]     ld_data,
    output logic                init_done
);
    localparam int IDX_W   = ADDR_LEN - 2;
    localparam int BANK_AW = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t               state_q, state_d;
    logic [BANK_AW-1:0]   clr_idx_q;
    logic [1:0]           fetch_tid;
    logic [IDX_W-1:0]     fetch_idx;
    logic                 in_range;
    logic                 running;
    logic                 clearing;
    logic                 ld_fire;
    logic                 rsp_nop_q;
    logic [3:0][XLEN-1:0] rd_data;
    logic                 unused_ld_idx;

    assign fetch_tid = fetch_addr[ADDR_LEN-1:ADDR_LEN-2];
    assign fetch_idx = fetch_addr[IDX_W-1:0];
    assign in_range  = {1'b0, fetch_idx} < (IDX_W+1)'(BANK_WORDS);
    assign running   = (state_q == ST_RUN);
    assign clearing  = (state_q == ST_CLEAR);

    // Load handshake: a write happens on any edge with ld_valid & ld_ready. ld_ready is
    // combinational, low during reset and CLEAR, and low while the fetch targets ld_tid;
    // the loader holds ld_* stable until accepted and never derives ld_valid from ld_ready.
    assign ld_ready = ~rst & running & ~(fetch_valid & (fetch_tid == ld_tid));
    assign ld_fire  = ld_valid & ld_ready;

    // Load index bits above the bank range are deliberately ignored.
    assign unused_ld_idx = ^ld_idx;

    always_comb begin
        state_d = state_q;
        if (clearing && (clr_idx_q == BANK_AW'(BANK_WORDS - 1))) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            init_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            init_done <= (state_d == ST_RUN);
            if (clearing) begin
                clr_idx_q <= clr_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_tid   <= 2'd0;
            rsp_fault <= 1'b0;
            rsp_nop_q <= 1'b1;
        end else begin
            rsp_valid <= fetch_valid;
            if (fetch_valid) begin
                rsp_tid   <= fetch_tid;
                rsp_fault <= running & ~in_range;
                rsp_nop_q <= ~running | ~in_range;
            end
        end
    end

    // Each bank's read register only moves when that bank is fetched, so the
    // selected word holds across idle cycles together with rsp_tid.
    assign rsp_data = rsp_nop_q ? NOP_WORD : rd_data[rsp_tid];

    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [XLEN-1:0]    mem [BANK_WORDS];
        logic [XLEN-1:0]    rd_q;
        logic               we;
        logic               re;
        logic [BANK_AW-1:0] waddr;
        logic [XLEN-1:0]    wdata;

        assign we    = clearing | (ld_fire & (ld_tid == 2'(b)));
        assign re    = running & fetch_valid & in_range & (fetch_tid == 2'(b));
        assign waddr = clearing ? clr_idx_q : ld_idx[BANK_AW-1:0];
        assign wdata = clearing ? NOP_WORD : ld_data;

        always_ff @(posedge clk) begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (re) begin
                rd_q <= mem[fetch_idx[BANK_AW-1:0]];
            end
        end

        assign rd_data[b] = rd_q;
    end
endmodule

// File: tb/tb_imem_responder.sv
// Randomized bench for imem_responder: driver pushes expected fetch responses from a
// word-array model; a negedge monitor pops and compares them, and checks hold/reset values.
module tb_imem_responder;
    localparam int          BW  = 256;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          W   = 35;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic [14:0] fetch_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_tid;
    logic        rsp_fault;
    logic        ld_valid;
    logic        ld_ready;
    logic [1:0]  ld_tid;
    logic [12:0] ld_idx;
    logic [31:0] ld_data;
    logic        init_done;

    imem_responder dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tid(rsp_tid), .rsp_fault(rsp_fault),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_tid(ld_tid), .ld_idx(ld_idx),
        .ld_data(ld_data), .init_done(init_done)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_err    = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0] model [4][BW];
    int          clr_edges = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: banks are plain word arrays; the block is in RUN once BW
    // non-reset edges have passed since the last reset edge.
    function automatic logic [W-1:0] expect_rsp(input logic [14:0] fa);
        logic [1:0]  tid;
        logic [12:0] idx;
        tid = fa[14:13];
        idx = fa[12:0];
        if (clr_edges < BW) return {1'b0, tid, NOP};
        if (int'(idx) < BW) return {1'b0, tid, model[tid][idx[7:0]]};
        return {1'b1, tid, NOP};
    endfunction

    // driver: one clock cycle of stimulus
    task automatic step(input logic r, input logic fv, input logic [14:0] fa,
                        input logic lv, input logic [1:0] lt, input logic [12:0] li,
                        input logic [31:0] ldat, output logic acc);
        logic exp_rdy;
        rst         = r;
        fetch_valid = fv;
        fetch_addr  = fa;
        ld_valid    = lv;
        ld_tid      = lt;
        ld_idx      = li;
        ld_data     = ldat;
        #1;
        exp_rdy = !r && (clr_edges >= BW) && !(fv && (fa[14:13] == lt));
        check("ld_ready", ld_ready, exp_rdy);
        acc = lv && exp_rdy;
        if (!r && fv) exp_q.push_back(expect_rsp(fa));
        if (acc) model[lt][int'(li) % BW] = ldat;
        @(posedge clk);
        if (r) begin
            clr_edges = 0;
            for (int t = 0; t < 4; t++)
                for (int k = 0; k < BW; k++) model[t][k] = NOP;
        end else begin
            clr_edges++;
        end
        #1;
        check("init_done", init_done, clr_edges >= BW);
    endtask

    // monitor / scoreboard
    logic         rst_s;
    logic         started = 1'b0;
    logic [W-1:0] last_rsp;
    logic [W-1:0] e;

    always @(posedge clk) rst_s <= rst;

    always @(negedge clk) begin
        if (rst_s === 1'b1) begin
            started = 1'b1;
            check("reset_rsp_valid", rsp_valid, 1'b0);
            check("reset_rsp", {rsp_fault, rsp_tid, rsp_data}, {1'b0, 2'd0, NOP});
            last_rsp = {1'b0, 2'd0, NOP};
        end else if (started) begin
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", rsp_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_fault_tid_data", {rsp_fault, rsp_tid, rsp_data}, e);
                    last_rsp = e;
                end
            end else begin
                check("rsp_valid_x", rsp_valid, 1'b0);
                check("rsp_hold", {rsp_fault, rsp_tid, rsp_data}, last_rsp);
            end
        end
    end

    logic        acc;
    logic        pend;
    logic [1:0]  p_tid;
    logic [12:0] p_idx;
    logic [31:0] p_dat;
    logic [12:0] f_idx;

    initial begin
        rst = 1'b1; fetch_valid = 1'b0; fetch_addr = '0;
        ld_valid = 1'b0; ld_tid = '0; ld_idx = '0; ld_data = '0;

        // Clear sequence with fetch held high
        step(1, 0, 15'd0, 0, 2'd0, 13'd0, 32'd0, acc);
        step(1, 0, 15'd0, 0, 2'd0, 13'd0, 32'd0, acc);
        for (int i = 0; i < BW + 4; i++)
            step(0, 1, 15'($urandom), 1'($urandom), 2'($urandom), 13'($urandom), $urandom, acc);

        // Load then fetch
        step(0, 1, {2'd0, 13'($urandom_range(0, 255))}, 1, 2'd2, 13'd5, 32'hDEADBEEF, acc);
        step(0, 1, {2'd2, 13'd5}, 0, 2'd0, 13'd0, 32'd0, acc);
        step(0, 0, 15'd0, 0, 2'd0, 13'd0, 32'd0, acc);

        // Bank conflict: stalled while fetch uses bank 1, lands when fetch moves to bank 3
        for (int i = 0; i < 4; i++)
            step(0, 1, {2'd1, 13'($urandom_range(0, 255))}, 1, 2'd1, 13'd7, 32'hCAFE0001, acc);
        step(0, 1, {2'd3, 13'($urandom_range(0, 255))}, 1, 2'd1, 13'd7, 32'hCAFE0001, acc);
        step(0, 1, {2'd1, 13'd7}, 0, 2'd0, 13'd0, 32'd0, acc);

        // Rotating thread fetch with a load held for bank 0
        pend = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, {2'(i % 4), 13'($urandom_range(0, 255))}, pend, 2'd0, 13'd9, 32'h12345678, acc);
            if (acc) pend = 1'b0;
        end
        step(0, 1, {2'd0, 13'd9}, 0, 2'd0, 13'd0, 32'd0, acc);

        // Out-of-range boundary
        step(0, 1, {2'd0, 13'h0100}, 0, 2'd0, 13'd0, 32'd0, acc);
        step(0, 1, {2'd0, 13'h00FF}, 0, 2'd0, 13'd0, 32'd0, acc);
        step(0, 1, {2'd3, 13'h1FFF}, 0, 2'd0, 13'd0, 32'd0, acc);
        step(0, 0, 15'd0, 0, 2'd0, 13'd0, 32'd0, acc);

        // Random traffic; loader holds each request until accepted
        pend = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend  = 1'b1;
                p_tid = 2'($urandom);
                p_idx = {5'($urandom), ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31)) : 8'($urandom)};
                p_dat = $urandom;
            end
            case ($urandom_range(0, 7))
                0:       f_idx = 13'($urandom_range(256, 8191));
                1, 2, 3: f_idx = 13'($urandom_range(0, 31));
                default: f_idx = 13'($urandom_range(0, 255));
            endcase
            step(0, $urandom_range(0, 3) != 0, {2'($urandom), f_idx}, pend, p_tid, p_idx, p_dat, acc);
            if (acc) pend = 1'b0;
        end

        // Reset mid-operation
        for (int k = 0; k < 10; k++)
            step(0, 0, 15'd0, 1, 2'(k % 4), 13'(20 + k), 32'hA5A50000 + k, acc);
        step(1, 1, {2'd1, 13'd3}, 1, 2'd2, 13'd40, 32'h00000BAD, acc);
        for (int i = 0; i < BW + 2; i++)
            step(0, 1, 15'($urandom), 0, 2'd0, 13'd0, 32'd0, acc);
        for (int k = 0; k < 10; k++)
            step(0, 1, {2'(k % 4), 13'(20 + k)}, 0, 2'd0, 13'd0, 32'd0, acc);

        for (int i = 0; i < 3; i++)
            step(0, 0, 15'd0, 0, 2'd0, 13'd0, 32'd0, acc);
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Memory-side responder for the instruction fetch path, and the far end of the fetch interface.
- Accepts one word-addressed fetch per cycle from the fetch unit. The address is {thread_id, pc}.
- Returns the instruction word one cycle later from a per-thread bank. Four banks, one per hardware thread.
- Provides a program-load write port that borrows a bank only when the barrel-thread fetch is not using it.
- After reset, a clear sequencer fills every bank with NOP before normal operation starts.

Parameters:
- XLEN, 32, instruction/data word width.
- ADDR_LEN, 15, fetch address width: bits [ADDR_LEN-1:ADDR_LEN-2] = thread id, bits [ADDR_LEN-3:0] = word index.
- BANK_WORDS, 256, words per thread bank; must be a power of 2 and no greater than 2**(ADDR_LEN-2).
- NOP_WORD, 32'h0000_0013, word returned for faults and during clear.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fetch_valid  in  1  fetch request this cycle
- fetch_addr  in  ADDR_LEN  {tid, word index}
- rsp_valid  out  1  response valid (registered)
- rsp_data  out  XLEN  instruction word
- rsp_tid  out  2  thread id of the response
- rsp_fault  out  1  index was out of bank range
- ld_valid  in  1  load write request
- ld_ready  out  1  load write accepted this cycle (combinational)
- ld_tid  in  2  target bank
- ld_idx  in  ADDR_LEN-2  word index in the bank
- ld_data  in  XLEN  write data
- init_done  out  1  clear sequence complete

Behaviour:
- Reset, while rst=1 and on the cycle after it deasserts:
  - rsp_valid=0, rsp_data=NOP_WORD, rsp_tid=0, rsp_fault=0, init_done=0.
  - FSM=CLEAR, clear index=0.
  - Bank contents are undefined until CLEAR completes.
- FSM states:
  - CLEAR: each cycle writes NOP_WORD to index clr_idx in all four banks, then clr_idx++. When clr_idx==BANK_WORDS-1 is written, the next state is RUN and init_done goes to 1 on that same edge. CLEAR lasts exactly BANK_WORDS cycles.
  - RUN: terminal state; only rst leaves it.
- Fetch latency:
  - A request sampled at edge N produces rsp_* valid after edge N+1.
  - rsp_valid = registered fetch_valid.
  - rsp_tid = registered fetch_addr[ADDR_LEN-1:ADDR_LEN-2].
- Fetch in CLEAR: rsp_valid follows fetch_valid, rsp_data=NOP_WORD, rsp_fault=0. The banks are not read.
- Fetch in RUN:
  - If word index < BANK_WORDS: rsp_data = bank[tid][index], rsp_fault=0.
  - Otherwise: rsp_data=NOP_WORD, rsp_fault=1.
- When fetch_valid=0: rsp_valid=0; rsp_data, rsp_tid and rsp_fault hold their previous values.
- Load handshake:
  - ld_ready = (FSM==RUN) & ~(fetch_valid & fetch tid==ld_tid).
  - A write occurs on an edge where ld_valid & ld_ready. It writes bank[ld_tid][ld_idx mod BANK_WORDS].
  - Upper index bits beyond the bank range are ignored for loads; no fault is raised.
  - The loader must hold ld_* stable until accepted.
  - ld_ready is combinational; ld_valid must not depend on ld_ready.
- Simultaneous events:
  - A fetch and a load to the same bank in the same cycle is impossible by construction: the load is stalled.
  - A fetch and a load to different banks both proceed in the same cycle.
- Read-after-write: a fetch of a word written at edge N returns the new data if the fetch is sampled at edge N+1 or later.
- Each bank is a 1R-or-1W synchronous RAM per cycle. The fetch read and the load write never target the same bank in one cycle.
- Reset mid-RUN: returns to CLEAR and clears init_done. Any pending load is dropped (ld_ready=0). The bank is re-cleared to NOP.
- Reset mid-CLEAR: restarts at index 0.

Test Plan:
- Clear sequence, BANK_WORDS=256: pulse rst for 2 cycles, then fetch_valid=1 continuously.
  - init_done must rise exactly 256 cycles after rst deasserts.
  - During CLEAR, all responses are 32'h13 with fault=0.
- Load then fetch: in RUN, load tid=2, idx=5, data=32'hDEADBEEF while fetching tid=0. Accepted in the same cycle. The next cycle, fetch addr {2,5} -> one cycle later rsp_data=32'hDEADBEEF, rsp_tid=2.
- Bank conflict: fetch tid=1 every cycle while ld_valid for tid=1.
  - ld_ready must stay 0.
  - Switch the fetch to tid=3: ld_ready=1 that cycle and the write lands.
  - A later fetch of {1,idx} returns the data.
- Rotating threads: fetch tid 0,1,2,3,0,... with ld_valid held for tid=0. Accepted on the first cycle fetch tid != 0 (≤1-cycle wait). Verify no fetch response is corrupted.
- Out of range: fetch {0, 13'h0100} with BANK_WORDS=256 -> rsp_fault=1, rsp_data=32'h13. Fetch {0,13'h00FF} -> fault=0.
- Reset mid-operation: load 10 distinct words, assert rst for 1 cycle.
  - ld_ready must drop to 0.
  - After init_done, all 10 locations read back 32'h13.
  - rsp_valid=0 on the first cycle after rst deasserts.
